// File: rtl/mem_arbiter_pkg.sv
// Shared op codes, error bit positions and FSM encoding for the memory arbiter.
package mem_arbiter_pkg;
  localparam int IOSTATEWIDTH = 2;

  localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'b00;
  localparam logic [IOSTATEWIDTH-1:0] RD   = 2'b01;
  localparam logic [IOSTATEWIDTH-1:0] WT   = 2'b10;
  localparam logic [IOSTATEWIDTH-1:0] ILL  = 2'b11;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_ILLEGAL = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr that is
// not masked out.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);
  logic [NREQ-1:0] elig;

  always_comb begin
    elig  = req & ~mask;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      automatic int j = (int'(ptr) + k) % NREQ;
      if (!valid && elig[PW'(j)]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one variable-latency memory port between
// NREQ caches, with a WAIT watchdog and sticky error bits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDRW   = 8,
  parameter int WORDW   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*NREQ-1:0]       req_rw,
  input  logic [NREQ*ADDRW-1:0]   req_addr,
  input  logic [NREQ*WORDW-1:0]   req_wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_done,
  output logic                    rsp_err,
  output logic [WORDW-1:0]        rsp_rdata,
  output logic [1:0]              mem_rw,
  output logic [ADDRW-1:0]        mem_addr,
  output logic [WORDW-1:0]        mem_wdata,
  input  logic                    mem_done,
  input  logic [WORDW-1:0]        mem_rdata,
  output logic [1:0]              err
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  state_t            state, nstate;
  logic [PW-1:0]     ptr, own, win;
  logic [NREQ-1:0]   mask, req, win_oh;
  logic              win_vld, tmo;
  logic [TW-1:0]     timer;
  logic [1:0]        win_rw;
  logic [ADDRW-1:0]  win_addr;
  logic [WORDW-1:0]  win_wdata;

  always_comb begin
    req       = '0;
    win_rw    = IDEL;
    win_addr  = '0;
    win_wdata = '0;
    win_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req[i] = req_rw[2*i +: 2] != IDEL;
      if (PW'(i) == win) begin
        win_rw    = req_rw[2*i +: 2];
        win_addr  = req_addr[ADDRW*i +: ADDRW];
        win_wdata = req_wdata[WORDW*i +: WORDW];
      end
    end
    win_oh[win] = 1'b1;
  end

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .mask  (mask),
    .ptr   (ptr),
    .valid (win_vld),
    .idx   (win)
  );

  assign tmo = timer == TW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (win_vld) nstate = (win_rw == ILL) ? S_RESP : S_WAIT;
      S_WAIT: if (mem_done || tmo) nstate = S_RESP;
      S_RESP: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // All outputs are registered; rsp_done/rsp_err are loaded on entry to RESP
  // so the pulse lines up with the RESP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      own       <= '0;
      mask      <= '0;
      timer     <= '0;
      gnt       <= '0;
      rsp_done  <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_rw    <= IDEL;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= '0;
    end else begin
      rsp_done <= '0;
      rsp_err  <= 1'b0;
      mask     <= '0;
      case (state)
        S_IDLE: if (win_vld) begin
          own <= win;
          gnt <= win_oh;
          if (win_rw == ILL) begin
            err[ERR_ILLEGAL] <= 1'b1;
            rsp_done         <= win_oh;
            rsp_err          <= 1'b1;
          end else begin
            mem_rw    <= win_rw;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            timer     <= '0;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            mem_rw    <= IDEL;
            rsp_done  <= gnt;
            rsp_rdata <= (mem_rw == RD) ? mem_rdata : '0;
          end else if (tmo) begin
            err[ERR_TIMEOUT] <= 1'b1;
            mem_rw           <= IDEL;
            rsp_done         <= gnt;
            rsp_err          <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          gnt       <= '0;
          rsp_rdata <= '0;
          mask      <= gnt;
          ptr       <= (own == PW'(NREQ - 1)) ? '0 : own + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, write/mask, fairness, timeout,
// illegal op and reset during WAIT, with hand-derived cycle expectations.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int NREQ = 4, ADDRW = 8, WORDW = 32, TIMEOUT = 64;

  logic                  clk = 1'b0, reset = 1'b1;
  logic [2*NREQ-1:0]     req_rw = '0;
  logic [NREQ*ADDRW-1:0] req_addr = '0;
  logic [NREQ*WORDW-1:0] req_wdata = '0;
  logic [NREQ-1:0]       gnt, rsp_done;
  logic                  rsp_err, mem_done = 1'b0;
  logic [WORDW-1:0]      rsp_rdata, mem_wdata, mem_rdata = '0;
  logic [1:0]            mem_rw, err;
  logic [ADDRW-1:0]      mem_addr;

  int n_chk = 0, n_err = 0;

  mem_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .WORDW(WORDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_done(rsp_done), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] rw, input logic [7:0] a,
                         input logic [31:0] d);
    req_rw[2*i +: 2]         = rw;
    req_addr[ADDRW*i +: ADDRW] = a;
    req_wdata[WORDW*i +: WORDW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_rw = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] eg, ed;
    // reset state
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", rsp_done, 0);
    chk("rst_rerr", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_mrw", mem_rw, IDEL);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    chk("rst_err", err, 0);

    // single read by requester 2, memory answers after 3 cycles
    do_reset();
    set_req(2, RD, 8'h05, 0);
    mem_done = 1'b0;
    tick();                                   // c1
    chk("rd_gnt", gnt, 4'b0100);
    chk("rd_mrw", mem_rw, RD);
    chk("rd_maddr", mem_addr, 8'h05);
    tick(); tick(); tick();                   // c4
    chk("rd_early_done", rsp_done, 0);
    mem_done = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();                                   // c5
    chk("rd_done", rsp_done, 4'b0100);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_rerr", rsp_err, 0);
    chk("rd_mrw_idle", mem_rw, IDEL);
    mem_done = 1'b0;
    tick();                                   // c6
    chk("rd_done_1cyc", rsp_done, 0);
    chk("rd_gnt_clr", gnt, 0);
    set_req(2, IDEL, 0, 0);

    // write by requester 1 held continuously: masked IDLE cycle, no rdata
    do_reset();
    set_req(1, WT, 8'h33, 32'hCAFEF00D);
    mem_done = 1'b1;
    mem_rdata = 32'h12345678;
    tick();                                   // c1
    chk("wt_gnt", gnt, 4'b0010);
    chk("wt_mrw", mem_rw, WT);
    chk("wt_mwdata", mem_wdata, 32'hCAFEF00D);
    tick();                                   // c2
    chk("wt_done", rsp_done, 4'b0010);
    chk("wt_rdata0", rsp_rdata, 0);
    tick();                                   // c3
    chk("mask_gnt_c3", gnt, 0);
    tick();                                   // c4
    chk("mask_gnt_c4", gnt, 0);
    tick();                                   // c5
    chk("mask_regnt", gnt, 4'b0010);
    tick();                                   // c6
    chk("mask_done2", rsp_done, 4'b0010);

    // fairness: all four request, 1-cycle memory -> 0,1,2,3,0 every 3 cycles
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, RD, 8'(i), 0);
    mem_done = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      eg = '0;
      ed = '0;
      if ((c - 1) % 3 < 2) eg[((c - 1) / 3) % 4] = 1'b1;
      if ((c - 1) % 3 == 1) ed[((c - 1) / 3) % 4] = 1'b1;
      chk($sformatf("rr_gnt_c%0d", c), gnt, eg);
      chk($sformatf("rr_done_c%0d", c), rsp_done, ed);
    end

    // timeout: memory never answers
    do_reset();
    set_req(0, RD, 8'h10, 0);
    mem_done = 1'b0;
    tick();                                   // c1
    chk("to_gnt", gnt, 4'b0001);
    for (int c = 2; c <= 64; c++) tick();     // c64
    chk("to_mrw_held", mem_rw, RD);
    chk("to_no_done", rsp_done, 0);
    chk("to_err_pre", err, 0);
    tick();                                   // c65
    chk("to_mrw_idle", mem_rw, IDEL);
    chk("to_done", rsp_done, 4'b0001);
    chk("to_rerr", rsp_err, 1);
    chk("to_err", err, 2'b01);
    tick();                                   // c66
    set_req(0, IDEL, 0, 0);
    set_req(2, WT, 8'h20, 32'h55AA55AA);
    mem_done = 1'b1;
    tick();                                   // c67
    chk("post_to_gnt", gnt, 4'b0100);
    chk("post_to_mrw", mem_rw, WT);
    tick();                                   // c68
    chk("post_to_done", rsp_done, 4'b0100);
    chk("post_to_rerr", rsp_err, 0);
    chk("post_to_err", err, 2'b01);

    // illegal op from requester 3
    tick();                                   // c69
    set_req(2, IDEL, 0, 0);
    set_req(3, ILL, 8'h44, 0);
    tick();                                   // c70
    chk("ill_gnt", gnt, 4'b1000);
    chk("ill_done", rsp_done, 4'b1000);
    chk("ill_rerr", rsp_err, 1);
    chk("ill_mrw", mem_rw, IDEL);
    chk("ill_err", err, 2'b11);
    tick();                                   // c71
    chk("ill_done_clr", rsp_done, 0);
    set_req(3, IDEL, 0, 0);
    set_req(0, WT, 8'h01, 32'h1);
    tick();                                   // c72
    chk("wrap_gnt0", gnt, 4'b0001);
    tick();                                   // c73, ptr moves to 1

    // reset during the second WAIT cycle of requester 1
    tick();                                   // c74
    set_req(0, IDEL, 0, 0);
    set_req(1, RD, 8'h02, 0);
    mem_done = 1'b0;
    tick();                                   // c75, WAIT 1
    chk("rw_gnt1", gnt, 4'b0010);
    tick();                                   // c76, WAIT 2
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, RD, 8'h80 + 8'(i), 0);
    tick();                                   // c77
    chk("rw_gnt", gnt, 0);
    chk("rw_done", rsp_done, 0);
    chk("rw_rerr", rsp_err, 0);
    chk("rw_mrw", mem_rw, IDEL);
    chk("rw_maddr", mem_addr, 0);
    chk("rw_err", err, 0);
    reset = 1'b0;
    mem_done = 1'b1;
    tick();                                   // c78
    chk("rw_first_gnt", gnt, 4'b0001);
    chk("rw_no_done", rsp_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
